// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller. Tracks the destination registers
// held in EX/MEM/WB, picks operand forwarding sources, raises load-use and
// branch-operand interlocks, freezes on data-memory stalls (with overrun
// detection) and squashes IF/ID on taken control transfers.
//
// state | meaning
// RUN   | pipeline moving, no memory stall in progress
// MWAIT | memory stall in progress, wait counter running
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_we,
    input  logic [4:0]       id_waddr,
    input  logic             id_is_load,
    input  logic             id_branch_op,
    input  logic             id_jump_op,
    input  logic             id_jalr_op,
    input  logic             take_branch,
    input  logic             mem_stall_req,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             if_stall,
    output logic             id_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

    typedef struct packed {
        logic       vld;
        logic       we;
        logic [4:0] waddr;
        logic       is_load;
    } slot_t;

    // The WB load flag is never consulted, so the WB slot does not keep it.
    typedef struct packed {
        logic       vld;
        logic       we;
        logic [4:0] waddr;
    } wb_slot_t;

    localparam logic [7:0] WAIT_TC = 8'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             to_done_q, to_done_d;
    logic             out_en_q;
    slot_t            ex_q, ex_d, mem_q, mem_d;
    wb_slot_t         wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall_w, at_tc_w, timeout_w;
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic load_use_w, br_chk1_w, br_chk2_w, br_haz_w, hazard_w;

    function automatic logic hit(input logic vld, input logic we,
                                 input logic [4:0] waddr, input logic [4:0] r);
        return vld & we & (waddr == r) & (r != 5'd0);
    endfunction

    // EX is skipped when it holds a load: its data is not ready yet.
    function automatic logic [1:0] fwd_pick(input logic used, input logic ex_h,
                                            input logic ex_ld, input logic mem_h,
                                            input logic wb_h);
        if (!used)          return 2'b00;
        if (ex_h && !ex_ld) return 2'b01;
        if (mem_h)          return 2'b10;
        if (wb_h)           return 2'b11;
        return 2'b00;
    endfunction

    assign ex_hit1  = hit(ex_q.vld,  ex_q.we,  ex_q.waddr,  id_rs1);
    assign ex_hit2  = hit(ex_q.vld,  ex_q.we,  ex_q.waddr,  id_rs2);
    assign mem_hit1 = hit(mem_q.vld, mem_q.we, mem_q.waddr, id_rs1);
    assign mem_hit2 = hit(mem_q.vld, mem_q.we, mem_q.waddr, id_rs2);
    assign wb_hit1  = hit(wb_q.vld,  wb_q.we,  wb_q.waddr,  id_rs1);
    assign wb_hit2  = hit(wb_q.vld,  wb_q.we,  wb_q.waddr,  id_rs2);

    assign load_use_w = ex_q.is_load & ((id_rs1_used & ex_hit1) | (id_rs2_used & ex_hit2));
    assign br_chk1_w  = (id_branch_op | id_jalr_op) & id_rs1_used;
    assign br_chk2_w  = id_branch_op & id_rs2_used;
    assign br_haz_w   = (br_chk1_w & (ex_hit1 | (mem_hit1 & mem_q.is_load)))
                      | (br_chk2_w & (ex_hit2 | (mem_hit2 & mem_q.is_load)));
    assign hazard_w   = id_valid & (load_use_w | br_haz_w);

    // Outputs stay quiet until the first clock edge after reset release.
    assign mem_stall_w = out_en_q & mem_stall_req;
    assign at_tc_w     = (wait_cnt_q == WAIT_TC);
    assign timeout_w   = mem_stall_w & at_tc_w & ~to_done_q;
    assign stall_cnt   = stall_cnt_q;

    // State register and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            to_done_q  <= 1'b0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_done_q  <= to_done_d;
            out_en_q   <= 1'b1;
        end
    end

    // Next state: the counter saturates at the terminal value so the overrun pulse fires once
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_done_d  = to_done_q;
        case (state_q)
            RUN: begin
                if (mem_stall_w) begin
                    state_d    = MWAIT;
                    wait_cnt_d = at_tc_w ? wait_cnt_q : wait_cnt_q + 8'd1;
                    to_done_d  = timeout_w;
                end else begin
                    wait_cnt_d = '0;
                    to_done_d  = 1'b0;
                end
            end
            MWAIT: begin
                if (!mem_stall_w) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    to_done_d  = 1'b0;
                end else begin
                    wait_cnt_d = at_tc_w ? wait_cnt_q : wait_cnt_q + 8'd1;
                    to_done_d  = to_done_q | timeout_w;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
                to_done_d  = 1'b0;
            end
        endcase
    end

    // Outputs: memory stall overrides interlocks, interlocks override flush
    always_comb begin
        fwd_a_sel   = 2'b00;
        fwd_b_sel   = 2'b00;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        mem_stall   = 1'b0;
        mem_timeout = 1'b0;
        if (out_en_q) begin
            fwd_a_sel   = fwd_pick(id_rs1_used, ex_hit1, ex_q.is_load, mem_hit1, wb_hit1);
            fwd_b_sel   = fwd_pick(id_rs2_used, ex_hit2, ex_q.is_load, mem_hit2, wb_hit2);
            mem_timeout = timeout_w;
            if (mem_stall_w) begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                mem_stall = 1'b1;
            end else if (hazard_w) begin
                if_stall    = 1'b1;
                id_stall    = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                ifid_flush = id_valid & (id_jump_op | (id_branch_op & take_branch));
            end
        end
    end

    // Scoreboard shift and stall statistics
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (out_en_q && !mem_stall_w) begin
            wb_d  = '{vld: mem_q.vld, we: mem_q.we, waddr: mem_q.waddr};
            mem_d = ex_q;
            ex_d  = '{vld: id_valid & ~idex_bubble, we: id_we, waddr: id_waddr,
                      is_load: id_is_load};
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(if_stall);
    end

    // Scoreboard and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized stimulus, reference model of the
// EX/MEM/WB pipeline as an array, scoreboard queue popped by a monitor.
module tb_hazard_ctrl;
    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_waddr = '0;
    logic             id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_we = 1'b0;
    logic             id_is_load = 1'b0, id_branch_op = 1'b0, id_jump_op = 1'b0;
    logic             id_jalr_op = 1'b0, take_branch = 1'b0, mem_stall_req = 1'b0;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             if_stall, id_stall, idex_bubble, ifid_flush, mem_stall, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .id_branch_op(id_branch_op), .id_jump_op(id_jump_op), .id_jalr_op(id_jalr_op),
        .take_branch(take_branch), .mem_stall_req(mem_stall_req),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .if_stall(if_stall), .id_stall(id_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .mem_stall(mem_stall), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n, vld, u1, u2, we, ld, br, jmp, jalr, take, req;
        int rs1, rs2, wa;
    } stim_t;

    typedef struct packed {
        logic [1:0]       fa, fb;
        logic             ifs, ids, bub, fl, ms, mto;
        logic [CNT_W-1:0] sc;
    } obs_t;

    typedef struct { string tag; obs_t o; } sb_t;

    typedef struct { bit v, we, ld; int wa; } mslot_t;

    sb_t              exp_q[$];
    int               n_vec = 0;
    int               n_bad = 0;

    // reference model state: index 0 = EX, 1 = MEM, 2 = WB
    mslot_t           pipe[3];
    bit               m_active = 1'b0;
    int               m_run = 0;
    logic [CNT_W-1:0] m_scnt = '0;

    function automatic bit m_writes(int i, int r);
        return pipe[i].v && pipe[i].we && pipe[i].wa == r && r != 0;
    endfunction

    function automatic logic [1:0] m_fwd(bit used, int r);
        if (!used || r == 0) return 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (m_writes(i, r)) begin
                if (i == 0 && pipe[0].ld) continue;
                return 2'(i + 1);
            end
        end
        return 2'b00;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst_n: 1'b1, default: 0};
        return s;
    endfunction

    function automatic stim_t alu(int rd, int a, int b);
        stim_t s = nop();
        s.vld = 1; s.we = 1; s.wa = rd; s.rs1 = a; s.rs2 = b; s.u1 = 1; s.u2 = 1;
        return s;
    endfunction

    function automatic stim_t lw(int rd, int a);
        stim_t s = nop();
        s.vld = 1; s.we = 1; s.wa = rd; s.rs1 = a; s.u1 = 1; s.ld = 1;
        return s;
    endfunction

    function automatic stim_t beq(int a, int b, bit tk);
        stim_t s = nop();
        s.vld = 1; s.rs1 = a; s.rs2 = b; s.u1 = 1; s.u2 = 1; s.br = 1; s.take = tk;
        return s;
    endfunction

    function automatic stim_t rnd_stim(bit req);
        stim_t s = nop();
        s.vld  = ($urandom_range(0, 9) != 0);
        s.rs1  = int'($urandom_range(0, 7));
        s.rs2  = int'($urandom_range(0, 7));
        s.wa   = int'($urandom_range(0, 7));
        s.u1   = ($urandom_range(0, 3) != 0);
        s.u2   = ($urandom_range(0, 3) != 0);
        s.we   = ($urandom_range(0, 3) != 0);
        s.ld   = ($urandom_range(0, 2) == 0);
        s.br   = ($urandom_range(0, 4) == 0);
        s.jmp  = ($urandom_range(0, 9) == 0);
        s.jalr = ($urandom_range(0, 9) == 0);
        s.take = ($urandom_range(0, 1) == 1);
        s.req  = req;
        return s;
    endfunction

    // Apply one cycle of stimulus and queue the response the rules predict for it.
    task automatic issue(input stim_t s, input string tag);
        sb_t  ent;
        bit   lu, bh, haz;
        @(posedge clk);
        #1;
        rst           = s.rst_n;
        id_valid      = s.vld;
        id_rs1        = 5'(s.rs1);
        id_rs2        = 5'(s.rs2);
        id_rs1_used   = s.u1;
        id_rs2_used   = s.u2;
        id_we         = s.we;
        id_waddr      = 5'(s.wa);
        id_is_load    = s.ld;
        id_branch_op  = s.br;
        id_jump_op    = s.jmp;
        id_jalr_op    = s.jalr;
        take_branch   = s.take;
        mem_stall_req = s.req;
        ent.tag = tag;
        ent.o   = '0;
        if (!s.rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, we: 0, ld: 0, wa: 0};
            m_active = 1'b0;
            m_run    = 0;
            m_scnt   = '0;
        end else if (!m_active) begin
            m_active = 1'b1;
            ent.o.sc = m_scnt;
        end else begin
            ent.o.fa = m_fwd(s.u1, s.rs1);
            ent.o.fb = m_fwd(s.u2, s.rs2);
            lu  = pipe[0].ld && ((s.u1 && m_writes(0, s.rs1)) || (s.u2 && m_writes(0, s.rs2)));
            bh  = ((s.br || s.jalr) && s.u1 && (m_writes(0, s.rs1) || (pipe[1].ld && m_writes(1, s.rs1))))
               || (s.br && s.u2 && (m_writes(0, s.rs2) || (pipe[1].ld && m_writes(1, s.rs2))));
            haz = s.vld && (lu || bh);
            if (s.req) begin
                ent.o.ifs = 1; ent.o.ids = 1; ent.o.ms = 1;
                m_run++;
                ent.o.mto = (m_run == MAX_WAIT);
            end else begin
                m_run = 0;
                if (haz) begin
                    ent.o.ifs = 1; ent.o.ids = 1; ent.o.bub = 1;
                end else begin
                    ent.o.fl = s.vld && (s.jmp || (s.br && s.take));
                end
            end
            ent.o.sc = m_scnt;
            if (ent.o.ifs) m_scnt++;
            if (!s.req) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = '{v: s.vld && !ent.o.bub, we: s.we, ld: s.ld, wa: s.wa};
            end
        end
        exp_q.push_back(ent);
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        sb_t  e;
        obs_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{fa: fwd_a_sel, fb: fwd_b_sel, ifs: if_stall, ids: id_stall,
                        bub: idex_bubble, fl: ifid_flush, ms: mem_stall, mto: mem_timeout,
                        sc: stall_cnt};
                n_vec++;
                if (act !== e.o) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got fa=%b fb=%b ifs=%b ids=%b bub=%b fl=%b ms=%b to=%b sc=%0d, want fa=%b fb=%b ifs=%b ids=%b bub=%b fl=%b ms=%b to=%b sc=%0d",
                             e.tag, $time, act.fa, act.fb, act.ifs, act.ids, act.bub, act.fl,
                             act.ms, act.mto, act.sc, e.o.fa, e.o.fb, e.o.ifs, e.o.ids,
                             e.o.bub, e.o.fl, e.o.ms, e.o.mto, e.o.sc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int    burst;
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, we: 0, ld: 0, wa: 0};

        s = nop(); s.rst_n = 0;
        repeat (3) issue(s, "reset");
        s = alu(4, 4, 4);
        issue(s, "post_reset");

        // load-use: lw x5 then add x6,x5,x1
        issue(lw(5, 1), "lu_load");
        issue(alu(6, 5, 1), "lu_stall");
        issue(alu(6, 5, 1), "lu_fwd_mem");
        repeat (3) issue(nop(), "drain");

        // EX forwarding, then the same with rs2 = x0
        issue(alu(5, 1, 1), "ex_prod");
        issue(alu(7, 1, 5), "ex_fwd");
        repeat (3) issue(nop(), "drain");
        issue(alu(5, 1, 1), "ex_prod0");
        issue(alu(7, 1, 0), "x0_nofwd");
        repeat (3) issue(nop(), "drain");

        // load feeding a branch: two interlock cycles, then flush with WB forward
        issue(lw(3, 1), "br_load");
        issue(beq(3, 4, 1), "br_stall1");
        issue(beq(3, 4, 1), "br_stall2");
        issue(beq(3, 4, 1), "br_flush");
        issue(nop(), "br_after");

        // memory stall held 20 cycles
        s = alu(8, 2, 2); s.req = 1;
        repeat (20) issue(s, "mstall");
        s.req = 0;
        issue(s, "mstall_end");
        repeat (3) issue(nop(), "drain");

        // EX/MEM/WB all write x2: EX wins; then reset in the middle of a stall
        repeat (3) issue(alu(2, 1, 1), "prio_prod");
        issue(alu(9, 2, 2), "prio_ex");
        s = alu(10, 2, 1); s.req = 1;
        repeat (5) issue(s, "pre_rst_stall");
        s.rst_n = 0;
        repeat (2) issue(s, "rst_mid_stall");
        s.rst_n = 1;
        issue(s, "rst_release");
        issue(alu(11, 2, 9), "rst_cleared");

        // randomized traffic with occasional memory-stall bursts and resets
        burst = 0;
        for (int n = 0; n < 2000; n++) begin
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = int'($urandom_range(1, 24));
            if ($urandom_range(0, 399) == 0) begin
                s = nop(); s.rst_n = 0;
                issue(s, "rnd_reset");
                burst = 0;
            end else begin
                issue(rnd_stim(burst > 0), "random");
                if (burst > 0) burst--;
            end
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the ID stage. It keeps a shadow scoreboard of the destination registers held in EX, MEM and WB. From that scoreboard it drives per-operand forwarding selects for the ID operand muxes and inserts load-use and branch-operand interlocks. It also freezes the pipeline on data-memory stalls (with a timeout) and flushes IF/ID on taken branches and jumps. It sits beside the ID stage and drives the IF/ID and ID/EX register stall/flush controls.

Parameters:
MAX_WAIT, 16, memory-stall cycles tolerated before mem_timeout pulses (1..255)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_we  in  1  ID instruction writes rd
id_waddr  in  5  ID destination register
id_is_load  in  1  ID instruction is a load
id_branch_op  in  1  conditional branch (comparator in ID)
id_jump_op  in  1  jal/jalr
id_jalr_op  in  1  jalr (reads rs1 in ID)
take_branch  in  1  comparator result
mem_stall_req  in  1  data memory busy
fwd_a_sel  out  2  00 RF, 01 EX, 10 MEM, 11 WB
fwd_b_sel  out  2  same encoding, rs2
if_stall  out  1  hold PC and IF/ID
id_stall  out  1  hold ID
idex_bubble  out  1  load NOP into ID/EX
ifid_flush  out  1  squash IF/ID contents
mem_stall  out  1  freeze all pipeline registers
mem_timeout  out  1  one-cycle pulse on memory stall overrun
stall_cnt  out  CNT_W  total stalled cycles, wraps

Behaviour:
- Slots EX, MEM and WB each hold {valid, we, waddr, is_load}.
- Advance (mem_stall=0): WB<=MEM, MEM<=EX, EX<=ID fields if id_valid & ~idex_bubble, else invalid. If mem_stall=1, all slots hold.
- A slot "writes r" when valid & we & waddr==r & r!=0.
- Forwarding (combinational) for each used operand, priority EX > MEM > WB:
  - EX only if the EX slot is not a load.
  - MEM allowed for loads.
  - Otherwise 00. rs==0 or operand unused gives 00.
- Load-use hazard: EX is a load writing a used rs.
- Branch hazard: id_branch_op, or id_jalr_op on rs1, with EX writing the rs, or MEM a load writing the rs.
- Any hazard with id_valid: if_stall=id_stall=idex_bubble=1, ifid_flush=0.
- Flush: ifid_flush=1 only when id_valid & ~hazard & ~mem_stall & (id_jump_op | id_branch_op & take_branch). take_branch is ignored during a hazard.
- FSM states RUN, MWAIT:
  - RUN -> MWAIT when mem_stall_req=1. mem_stall follows mem_stall_req combinationally in both states.
  - MWAIT: an 8-bit wait counter increments each cycle. It returns to RUN when mem_stall_req=0, clearing the counter.
  - When the counter reaches MAX_WAIT-1 with mem_stall_req still 1: mem_timeout=1 for one cycle, counter holds, state stays MWAIT.
  - While mem_stall=1, idex_bubble, ifid_flush and the slots are inhibited. if_stall=id_stall=1. mem_stall has priority over every other hazard.
- stall_cnt increments every cycle in which if_stall=1.
- Reset (rst=0, any time, asynchronous):
  - All slots invalid; state RUN; counters 0.
  - All outputs 0 during reset and in the first cycle after it.

Test Plan:
- EX = lw x5, ID = add x6,x5,x1 -> 1 cycle with if_stall=idex_bubble=1; next cycle fwd_a_sel=10; stall_cnt=1.
- EX = add x5, ID = sub x7,x1,x5 -> no stall, fwd_b_sel=01. Repeat with rs2=x0 -> fwd_b_sel=00.
- EX = lw x3, ID = beq x3,x4 -> 2 stall cycles, then fwd_a_sel=11. take_branch=1 during the stall produces no flush; after the stall, take_branch=1 -> ifid_flush=1 for 1 cycle.
- mem_stall_req held 20 cycles, MAX_WAIT=16 -> mem_stall=1 for 20 cycles, mem_timeout pulses once on the 16th cycle, slots unchanged, then returns to RUN.
- EX = add x2, MEM = add x2, WB = add x2, ID reads x2 -> fwd_a_sel=01 (EX priority). rst driven low mid-stall -> all outputs 0 immediately, slots cleared.
